// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory access path: size codes, extender codes,
// error codes and the load/store unit state encoding.
package mem_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  // Must stay in step with the codes decoded by mem_res_extender.
  localparam logic [2:0] EXT_NONE = 3'b000;
  localparam logic [2:0] EXT_LB   = 3'b001;
  localparam logic [2:0] EXT_LH   = 3'b010;
  localparam logic [2:0] EXT_LW   = 3'b011;
  localparam logic [2:0] EXT_LBU  = 3'b100;
  localparam logic [2:0] EXT_LHU  = 3'b101;

  localparam logic [1:0] ERR_NONE       = 2'b00;
  localparam logic [1:0] ERR_MISALIGNED = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT    = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_REQ    = 2'b01,
    ST_WAIT_R = 2'b10
  } lsu_state_e;

  // Size 11 behaves as a word, so it shares the word alignment rule.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return offset[0];
      default: return offset != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store-data replication, load
// right-alignment and mapping of size/signedness onto the extender code.
module lsu_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lanes,
  output logic [31:0] rdata_aligned,
  output logic [2:0]  ext_ctrl
);

  always_comb begin
    be          = 4'b1111;
    wdata_lanes = wdata;
    ext_ctrl    = EXT_LW;
    case (size)
      SIZE_B: begin
        be          = 4'b0001 << offset;
        wdata_lanes = {4{wdata[7:0]}};
        ext_ctrl    = is_unsigned ? EXT_LBU : EXT_LB;
      end
      SIZE_H: begin
        be          = 4'b0011 << {offset[1], 1'b0};
        wdata_lanes = {2{wdata[15:0]}};
        ext_ctrl    = is_unsigned ? EXT_LHU : EXT_LH;
      end
      default: ;
    endcase
  end

  // Upper bytes are zero-filled; sign/zero extension is the extender's job.
  assign rdata_aligned = rdata >> {offset, 3'b000};

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: alignment check, request/grant/response handshake
// to word-addressed data memory, and a watchdog that aborts unanswered accesses.
module load_store_unit
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        dmem_req,
  output logic [31:0] dmem_addr,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic [2:0]  res_ext_ctrl,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [1:0]  fsm_state
);

  // Handshake: the pipeline side transfers on req_valid & req_ready (ready only
  // in IDLE); the memory side holds dmem_req and its controls until dmem_gnt,
  // then the load response arrives on dmem_rvalid (possibly the same cycle).

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  lsu_state_e  state;
  logic [7:0]  cnt;
  logic        op_we;
  logic [1:0]  op_size;
  logic        op_unsigned;
  logic [31:0] op_addr;
  logic [31:0] op_wdata;

  logic [3:0]  be;
  logic [31:0] wdata_lanes;
  logic [31:0] rdata_aligned;
  logic [2:0]  ext_ctrl;

  lsu_align u_align (
    .size          (op_size),
    .is_unsigned   (op_unsigned),
    .offset        (op_addr[1:0]),
    .wdata         (op_wdata),
    .rdata         (dmem_rdata),
    .be            (be),
    .wdata_lanes   (wdata_lanes),
    .rdata_aligned (rdata_aligned),
    .ext_ctrl      (ext_ctrl)
  );

  logic in_req;
  logic done_req;
  logic done_wait;

  assign in_req    = (state == ST_REQ);
  assign done_req  = dmem_gnt && (op_we || dmem_rvalid);
  assign done_wait = dmem_rvalid;

  assign req_ready  = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign fsm_state  = state;
  // Memory controls are only meaningful in REQ; forced to zero elsewhere.
  assign dmem_req   = in_req;
  assign dmem_addr  = in_req ? {op_addr[31:2], 2'b00} : 32'd0;
  assign dmem_we    = in_req & op_we;
  assign dmem_be    = in_req ? be : 4'b0000;
  assign dmem_wdata = (in_req && op_we) ? wdata_lanes : 32'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= 8'd0;
      op_we        <= 1'b0;
      op_size      <= SIZE_B;
      op_unsigned  <= 1'b0;
      op_addr      <= 32'd0;
      op_wdata     <= 32'd0;
      res_valid    <= 1'b0;
      res_data     <= 32'd0;
      res_ext_ctrl <= EXT_NONE;
      err          <= 1'b0;
      err_code     <= ERR_NONE;
    end else begin
      res_valid <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            if (is_misaligned(req_size, req_addr[1:0])) begin
              err      <= 1'b1;
              err_code <= ERR_MISALIGNED;
            end else begin
              op_we       <= req_we;
              op_size     <= req_size;
              op_unsigned <= req_unsigned;
              op_addr     <= req_addr;
              op_wdata    <= req_wdata;
              cnt         <= 8'd0;
              state       <= ST_REQ;
            end
          end
        end
        ST_REQ, ST_WAIT_R: begin
          // Completion is checked before the watchdog so it wins a tie.
          if ((in_req && done_req) || (!in_req && done_wait)) begin
            res_valid    <= 1'b1;
            res_data     <= op_we ? 32'd0 : rdata_aligned;
            res_ext_ctrl <= op_we ? EXT_NONE : ext_ctrl;
            state        <= ST_IDLE;
          end else if (cnt == CNT_LAST) begin
            err      <= 1'b1;
            err_code <= ERR_TIMEOUT;
            state    <= ST_IDLE;
          end else begin
            cnt <= cnt + 8'd1;
            if (in_req && dmem_gnt) state <= ST_WAIT_R;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: one task per scenario, inline checks
// against hand-computed expectations, single summary line at the end.
module tb_load_store_unit;
  import mem_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        busy;
  logic        dmem_req;
  logic [31:0] dmem_addr;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        res_valid;
  logic [31:0] res_data;
  logic [2:0]  res_ext_ctrl;
  logic        err;
  logic [1:0]  err_code;
  logic [1:0]  fsm_state;

  int checks;
  int errors;

  load_store_unit #(.TIMEOUT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .busy         (busy),
    .dmem_req     (dmem_req),
    .dmem_addr    (dmem_addr),
    .dmem_we      (dmem_we),
    .dmem_be      (dmem_be),
    .dmem_wdata   (dmem_wdata),
    .dmem_gnt     (dmem_gnt),
    .dmem_rvalid  (dmem_rvalid),
    .dmem_rdata   (dmem_rdata),
    .res_valid    (res_valid),
    .res_data     (res_data),
    .res_ext_ctrl (res_ext_ctrl),
    .err          (err),
    .err_code     (err_code),
    .fsm_state    (fsm_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver tasks
  task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
  endtask

  task automatic clear_req();
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'hFFFF_FFFF;
    req_wdata    = 32'hFFFF_FFFF;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_req();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
    tick(); tick();
    checks++;
    if ({req_ready, busy, dmem_req, dmem_we, res_valid, err} !== 6'b100000) begin
      $display("FAIL reset_ctrl got %b expected 100000", {req_ready, busy, dmem_req, dmem_we, res_valid, err});
      errors++;
    end
    checks++;
    if ({dmem_addr, dmem_be, dmem_wdata, res_data, res_ext_ctrl, err_code} !== '0) begin
      $display("FAIL reset_data addr=%h be=%b wd=%h rd=%h ext=%b ec=%b expected all zero",
               dmem_addr, dmem_be, dmem_wdata, res_data, res_ext_ctrl, err_code);
      errors++;
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_lbu_fast();
    drive_req(1'b0, SIZE_B, 1'b1, 32'h0000_1003, 32'h0);
    tick();
    clear_req();
    checks++;
    if (dmem_req !== 1'b1 || dmem_addr !== 32'h0000_1000 || dmem_be !== 4'b1000 || dmem_we !== 1'b0) begin
      $display("FAIL lbu_req req=%b addr=%h be=%b we=%b expected 1 00001000 1000 0",
               dmem_req, dmem_addr, dmem_be, dmem_we);
      errors++;
    end
    dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h80FF_1234;
    tick();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    checks++;
    if (res_valid !== 1'b1 || res_data !== 32'h0000_0080 || res_ext_ctrl !== EXT_LBU || busy !== 1'b0) begin
      $display("FAIL lbu_res valid=%b data=%h ext=%b busy=%b expected 1 00000080 100 0",
               res_valid, res_data, res_ext_ctrl, busy);
      errors++;
    end
    tick();
    checks++;
    if (res_valid !== 1'b0 || res_data !== 32'h0000_0080 || res_ext_ctrl !== EXT_LBU) begin
      $display("FAIL lbu_hold valid=%b data=%h ext=%b expected 0 00000080 100",
               res_valid, res_data, res_ext_ctrl);
      errors++;
    end
  endtask

  task automatic test_sh_slow_grant();
    drive_req(1'b1, SIZE_H, 1'b0, 32'h0000_2002, 32'hABCD_5678);
    tick();
    clear_req();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) dmem_gnt = 1'b1;
      checks++;
      if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_be !== 4'b1100 ||
          dmem_wdata !== 32'h5678_5678 || dmem_addr !== 32'h0000_2000 || res_valid !== 1'b0) begin
        $display("FAIL sh_hold[%0d] req=%b we=%b be=%b wd=%h addr=%h rv=%b expected 1 1 1100 56785678 00002000 0",
                 i, dmem_req, dmem_we, dmem_be, dmem_wdata, dmem_addr, res_valid);
        errors++;
      end
      tick();
    end
    dmem_gnt = 1'b0;
    checks++;
    if (res_valid !== 1'b1 || res_data !== 32'h0 || res_ext_ctrl !== EXT_NONE || dmem_req !== 1'b0 || err !== 1'b0) begin
      $display("FAIL sh_res valid=%b data=%h ext=%b req=%b err=%b expected 1 00000000 000 0 0",
               res_valid, res_data, res_ext_ctrl, dmem_req, err);
      errors++;
    end
    tick();
  endtask

  task automatic test_misaligned();
    drive_req(1'b0, SIZE_W, 1'b0, 32'h0000_3001, 32'h0);
    tick();
    clear_req();
    checks++;
    if (err !== 1'b1 || err_code !== ERR_MISALIGNED || dmem_req !== 1'b0 ||
        req_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0) begin
      $display("FAIL misaligned err=%b code=%b req=%b ready=%b busy=%b rv=%b expected 1 01 0 1 0 0",
               err, err_code, dmem_req, req_ready, busy, res_valid);
      errors++;
    end
    tick();
    checks++;
    if (err !== 1'b0 || err_code !== ERR_NONE || dmem_req !== 1'b0) begin
      $display("FAIL misaligned_pulse err=%b code=%b req=%b expected 0 00 0", err, err_code, dmem_req);
      errors++;
    end
  endtask

  task automatic test_timeout();
    int busy_cycles;
    drive_req(1'b0, SIZE_H, 1'b0, 32'h0000_4000, 32'h0);
    tick();
    clear_req();
    checks++;
    if (dmem_be !== 4'b0011 || dmem_addr !== 32'h0000_4000) begin
      $display("FAIL lh_req be=%b addr=%h expected 0011 00004000", dmem_be, dmem_addr);
      errors++;
    end
    busy_cycles = 0;
    for (int i = 0; i < 10 && busy; i++) begin
      dmem_gnt = (i == 0);
      busy_cycles++;
      tick();
    end
    dmem_gnt = 1'b0;
    checks++;
    if (busy_cycles !== 4 || err !== 1'b1 || err_code !== ERR_TIMEOUT || busy !== 1'b0 || res_valid !== 1'b0) begin
      $display("FAIL timeout busy_cycles=%0d err=%b code=%b busy=%b rv=%b expected 4 1 10 0 0",
               busy_cycles, err, err_code, busy, res_valid);
      errors++;
    end
    dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_AAAA;
    tick();
    dmem_rvalid = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || err !== 1'b0 || busy !== 1'b0 || res_data !== 32'h0) begin
      $display("FAIL late_rvalid rv=%b err=%b busy=%b data=%h expected 0 0 0 00000000",
               res_valid, err, busy, res_data);
      errors++;
    end
  endtask

  task automatic test_back_to_back();
    drive_req(1'b0, SIZE_B, 1'b0, 32'h0000_5001, 32'h0);
    tick();
    clear_req();
    checks++;
    if (dmem_be !== 4'b0010 || dmem_addr !== 32'h0000_5000) begin
      $display("FAIL lb_req be=%b addr=%h expected 0010 00005000", dmem_be, dmem_addr);
      errors++;
    end
    dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    tick();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    checks++;
    if (res_valid !== 1'b1 || res_data !== 32'h00DE_ADBE || res_ext_ctrl !== EXT_LB || req_ready !== 1'b1) begin
      $display("FAIL lb_res valid=%b data=%h ext=%b ready=%b expected 1 00deadbe 001 1",
               res_valid, res_data, res_ext_ctrl, req_ready);
      errors++;
    end
    drive_req(1'b1, SIZE_W, 1'b0, 32'h0000_6000, 32'h1122_3344);
    tick();
    clear_req();
    checks++;
    if (res_valid !== 1'b0 || dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_be !== 4'b1111 ||
        dmem_wdata !== 32'h1122_3344 || dmem_addr !== 32'h0000_6000) begin
      $display("FAIL sw_req rv=%b req=%b we=%b be=%b wd=%h addr=%h expected 0 1 1 1111 11223344 00006000",
               res_valid, dmem_req, dmem_we, dmem_be, dmem_wdata, dmem_addr);
      errors++;
    end
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    checks++;
    if (res_valid !== 1'b1 || res_data !== 32'h0 || res_ext_ctrl !== EXT_NONE) begin
      $display("FAIL sw_res valid=%b data=%h ext=%b expected 1 00000000 000", res_valid, res_data, res_ext_ctrl);
      errors++;
    end
    tick();
  endtask

  task automatic test_reset_mid_access();
    drive_req(1'b0, SIZE_W, 1'b0, 32'h0000_7000, 32'h0);
    tick();
    clear_req();
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    checks++;
    if (fsm_state !== ST_WAIT_R || busy !== 1'b1) begin
      $display("FAIL wait_r_entry state=%b busy=%b expected 10 1", fsm_state, busy);
      errors++;
    end
    rst = 1'b1;
    #1;
    checks++;
    if (dmem_req !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 || res_valid !== 1'b0) begin
      $display("FAIL async_reset req=%b busy=%b ready=%b rv=%b expected 0 0 1 0",
               dmem_req, busy, req_ready, res_valid);
      errors++;
    end
    tick();
    rst = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
    tick();
    dmem_rvalid = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || res_data !== 32'h0) begin
      $display("FAIL post_reset_rvalid rv=%b busy=%b data=%h expected 0 0 00000000", res_valid, busy, res_data);
      errors++;
    end
    // Reset while the request is still outstanding must drop dmem_req at once.
    drive_req(1'b0, SIZE_W, 1'b0, 32'h0000_8000, 32'h0);
    tick();
    clear_req();
    checks++;
    if (dmem_req !== 1'b1) begin
      $display("FAIL req_before_reset req=%b expected 1", dmem_req);
      errors++;
    end
    rst = 1'b1;
    #1;
    checks++;
    if (dmem_req !== 1'b0 || dmem_addr !== 32'h0 || busy !== 1'b0) begin
      $display("FAIL async_reset_req req=%b addr=%h busy=%b expected 0 00000000 0", dmem_req, dmem_addr, busy);
      errors++;
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_lbu_fast();
    test_sh_slow_grant();
    test_misaligned();
    test_timeout();
    test_back_to_back();
    test_reset_mid_access();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequential data-memory access unit in the MEM stage of the RV32 core. Accepts one load/store per request from the pipeline, checks alignment, drives the word-addressed data-memory request/grant/response handshake with per-byte enables, and returns loaded data right-aligned together with the 3-bit extension code consumed by `mem_res_extender`. A watchdog aborts accesses that the memory never answers.

## Interface
- `TIMEOUT`, 255: cycles spent in REQ plus WAIT_R before abort; 8-bit counter, 1..255.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: pipeline presents an access.
- `req_ready` out 1: high only in IDLE; access accepted on `req_valid & req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word; 11 treated as word.
- `req_unsigned` in 1: lbu/lhu; ignored for word and for stores.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `busy` out 1: state != IDLE; pipeline holds MEM stage while high.
- `dmem_req` out 1: request to memory, held until grant.
- `dmem_addr` out 32: `{addr[31:2], 2'b00}`.
- `dmem_we` out 1, `dmem_be` out 4, `dmem_wdata` out 32: store controls, lane-replicated data.
- `dmem_gnt` in 1: memory accepted the request.
- `dmem_rvalid` in 1, `dmem_rdata` in 32: load response.
- `res_valid` out 1: one-cycle completion pulse (loads and stores).
- `res_data` out 32: load word shifted right by `addr[1:0]*8`, zero-filled; 0 for stores.
- `res_ext_ctrl` out 3: 001 lb, 010 lh, 011 lw, 100 lbu, 101 lhu, 000 store/error.
- `err` out 1, `err_code` out 2: one-cycle pulse; 01 misaligned, 10 timeout.

## Operation
- States: IDLE, REQ, WAIT_R.
- IDLE: on accept, misaligned (half with `addr[0]`, word with `addr[1:0]!=0`) -> no memory access, next cycle `err=1`, `err_code=01`, stay IDLE. Aligned -> latch op into registers, clear counter, go REQ.
- REQ: `dmem_req=1`, all `dmem_*` driven from latched registers, stable until grant. On `dmem_gnt`: store -> `res_valid` next cycle, IDLE; load -> WAIT_R. Load with `dmem_gnt & dmem_rvalid` in same cycle completes directly to IDLE.
- WAIT_R: on `dmem_rvalid`, register `res_data`, `res_ext_ctrl`, pulse `res_valid`, go IDLE.
- Byte enables: byte `4'b0001<<addr[1:0]`; half `4'b0011<<{addr[1],1'b0}`; word `4'b1111`. Store data: byte `{4{wdata[7:0]}}`, half `{2{wdata[15:0]}}`, word as-is.
- Watchdog: counter increments each cycle in REQ/WAIT_R; reaching `TIMEOUT` -> `err=1`, `err_code=10`, `dmem_req` drops, IDLE. Timeout and completion in the same cycle: completion wins.
- `dmem_rvalid`/`dmem_gnt` while IDLE ignored.

## Timing
- Reset values: all outputs 0 except `req_ready=1`; state IDLE; counter 0. Reset mid-access drops `dmem_req` immediately (asynchronous); late responses ignored.
- Minimum load latency: accept (cycle 0), REQ with gnt+rvalid (cycle 1), `res_valid` cycle 2. Store with immediate grant: `res_valid` cycle 2.
- `res_valid`, `err` are registered and high for exactly one cycle; `res_data`/`res_ext_ctrl` hold until next completion.
- Back-to-back: the cycle `res_valid` is high, state is IDLE and a new request may be accepted.
- `req_*` sampled only on the accept edge.

## Structure
- Shared package `mem_pkg`: size codes, extension codes (001..101, matching extender), error codes, state encoding.
- Sub-module `lsu_align`: combinational lane logic (be, store replication, load right-shift, ext-code mapping); FSM and watchdog stay in `load_store_unit`.

## Test plan
- lbu at 0x1003, rdata 0x80FF_1234, immediate gnt+rvalid -> `dmem_addr=0x1000`, `res_data=0x0000_0080`, `res_ext_ctrl=100`, `res_valid` cycle 2.
- sh 0xABCD_5678 at 0x2002, gnt after 3 cycles -> `dmem_be=1100`, `dmem_wdata=0x5678_5678`, `res_valid` one cycle after gnt.
- lw at 0x3001 -> no `dmem_req`, `err=1`, `err_code=01`, `req_ready` stays 1.
- lh at 0x4000, gnt but no rvalid, `TIMEOUT=4` -> `err_code=10` after 4 busy cycles, IDLE, later rvalid ignored.
- Back-to-back lb then sw: second request accepted in `res_valid` cycle, both complete with correct lanes.
- Assert `rst` during WAIT_R -> `dmem_req=0`, `busy=0`, `req_ready=1` immediately; no `res_valid`.
